fp13_stream_accumulator: RTL and testbench



---
 rtl/fp13_pkg.sv | 40 ++++
 rtl/fp13_normalize.sv | 59 +++++
 rtl/fp13_stream_accumulator.sv | 167 ++++++++++++++++
 tb/tb_fp13_stream_accumulator.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp13_pkg.sv
`default_nettype none
// ============================================================
// Package  : fp13_pkg
// Summary  : fp13 word layout, constants and accumulator states.
// Revision : 1.0
// ============================================================
package fp13_pkg;

  typedef struct packed {
    logic       sign;
    logic [3:0] exp;
    logic [7:0] frac;
  } fp13_t;

  localparam int          FP13_BIAS    = 7;
  localparam logic [12:0] FP13_ZERO    = 13'h0000;
  localparam int          FP13_EXP_MAX = 15;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ALIGN = 3'd1;
  localparam logic [2:0] ST_ADD   = 3'd2;
  localparam logic [2:0] ST_NORM  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_ALIGN = ST_ALIGN,
    S_ADD   = ST_ADD,
    S_NORM  = ST_NORM,
    S_DONE  = ST_DONE
  } fp13_acc_state_e;

  // exp==0 encodes zero regardless of the fraction bits
  function automatic logic [8:0] fp13_mant(input fp13_t x);
    return (x.exp == 4'd0) ? 9'd0 : {1'b1, x.frac};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp13_normalize.sv
`default_nettype none
// ============================================================
// Module   : fp13_normalize
// Summary  : single-cycle renormalisation of a 10-bit magnitude into fp13.
// Revision : 1.0
// ============================================================
module fp13_normalize
  import fp13_pkg::*;
(
  input  logic [9:0]        i_mag,
  input  logic signed [4:0] i_exp,
  input  logic              i_sign,
  output fp13_t             o_fp,
  output logic              o_range
);

  localparam logic signed [5:0] EXP_HI = 6'(FP13_EXP_MAX);

  logic [3:0]        w_lz;
  logic signed [5:0] w_exp;
  logic [7:0]        w_frac;

  // ascending scan: the highest set bit below bit 9 wins
  always_comb begin
    w_lz = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (i_mag[i]) w_lz = 4'(8 - i);
    end
  end

  always_comb begin
    if (i_mag[9]) begin
      w_exp  = {i_exp[4], i_exp} + 6'sd1;
      w_frac = i_mag[8:1];
    end else begin
      w_exp  = {i_exp[4], i_exp} - {2'b00, w_lz};
      w_frac = i_mag[7:0] << w_lz;
    end
  end

  always_comb begin
    o_fp    = FP13_ZERO;
    o_range = 1'b0;
    if (i_mag == 10'd0) begin
      o_fp = FP13_ZERO;
    end else if (w_exp > EXP_HI) begin
      o_fp    = '{sign: i_sign, exp: 4'hF, frac: 8'hFF};
      o_range = 1'b1;
    end else if (w_exp < 6'sd1) begin
      o_fp    = FP13_ZERO;
      o_range = 1'b1;
    end else begin
      o_fp = '{sign: i_sign, exp: w_exp[3:0], frac: w_frac};
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp13_stream_accumulator.sv
`default_nettype none
// ============================================================
// Module   : fp13_stream_accumulator
// Summary  : sums a packet of fp13 samples, four cycles per sample;
//            define FP13_ACC_OVF_FLAG_EN to add the sticky out_ovf port.
// Revision : 1.0
// ============================================================
module fp13_stream_accumulator
  import fp13_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [12:0]      in_fp,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [12:0]      out_fp,
  output logic [CNT_W-1:0] out_count
`ifdef FP13_ACC_OVF_FLAG_EN
  ,
  output logic             out_ovf
`endif
);

  fp13_acc_state_e  r_state;
  fp13_t            r_acc;
  fp13_t            r_smp;
  logic             r_last;
  logic [CNT_W-1:0] r_cnt;
  logic [8:0]       r_m_big;
  logic [8:0]       r_m_small;
  logic             r_s_big;
  logic             r_s_small;
  logic [3:0]       r_exp;
  logic [9:0]       r_mag;
  logic             r_sign;

  logic       w_acc_big;
  logic [3:0] w_ediff;
  logic [8:0] w_m_big;
  logic [8:0] w_m_small;
  logic [8:0] w_m_shift;
  logic [9:0] w_mag;
  logic       w_sign;
  fp13_t      w_norm;
  logic       w_range;

  // ALIGN: the larger-exponent operand keeps its mantissa, the other is truncated
  always_comb begin
    w_acc_big = (r_acc.exp >= r_smp.exp);
    if (w_acc_big) begin
      w_ediff   = r_acc.exp - r_smp.exp;
      w_m_big   = fp13_mant(r_acc);
      w_m_small = fp13_mant(r_smp);
    end else begin
      w_ediff   = r_smp.exp - r_acc.exp;
      w_m_big   = fp13_mant(r_smp);
      w_m_small = fp13_mant(r_acc);
    end
    w_m_shift = (w_ediff >= 4'd9) ? 9'd0 : (w_m_small >> w_ediff);
  end

  always_comb begin
    if (r_s_big == r_s_small) begin
      w_mag  = {1'b0, r_m_big} + {1'b0, r_m_small};
      w_sign = r_s_big;
    end else if (r_m_big >= r_m_small) begin
      w_mag  = {1'b0, r_m_big - r_m_small};
      w_sign = r_s_big;
    end else begin
      w_mag  = {1'b0, r_m_small - r_m_big};
      w_sign = r_s_small;
    end
  end

  fp13_normalize u_norm (
    .i_mag   (r_mag),
    .i_exp   ({1'b0, r_exp}),
    .i_sign  (r_sign),
    .o_fp    (w_norm),
    .o_range (w_range)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_acc     <= FP13_ZERO;
      r_smp     <= FP13_ZERO;
      r_last    <= 1'b0;
      r_cnt     <= '0;
      r_m_big   <= 9'd0;
      r_m_small <= 9'd0;
      r_s_big   <= 1'b0;
      r_s_small <= 1'b0;
      r_exp     <= 4'd0;
      r_mag     <= 10'd0;
      r_sign    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_smp   <= in_fp;
            r_last  <= in_last;
            if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
            r_state <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          r_m_big   <= w_m_big;
          r_m_small <= w_m_shift;
          r_s_big   <= w_acc_big ? r_acc.sign : r_smp.sign;
          r_s_small <= w_acc_big ? r_smp.sign : r_acc.sign;
          r_exp     <= w_acc_big ? r_acc.exp : r_smp.exp;
          r_state   <= S_ADD;
        end
        S_ADD: begin
          r_mag   <= w_mag;
          r_sign  <= w_sign;
          r_state <= S_NORM;
        end
        S_NORM: begin
          r_acc   <= w_norm;
          r_state <= r_last ? S_DONE : S_IDLE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_acc   <= FP13_ZERO;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_fp    = r_acc;
  assign out_count = r_cnt;

`ifdef FP13_ACC_OVF_FLAG_EN
  logic r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (r_state == S_NORM && w_range) begin
      r_ovf <= 1'b1;
    end else if (r_state == S_DONE && out_ready) begin
      r_ovf <= 1'b0;
    end
  end

  assign out_ovf = r_ovf;
`else
  logic w_unused_range;
  assign w_unused_range = w_range;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fp13_stream_accumulator.sv
`default_nettype none
// ============================================================
// Module   : tb_fp13_stream_accumulator
// Summary  : directed and random packets against an arithmetic fp13 model.
// Revision : 1.0
// ============================================================
module tb_fp13_stream_accumulator;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [12:0] fp;
    int          cnt;
    bit          ovf;
  } total_t;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             in_valid  = 1'b0;
  logic             in_last   = 1'b0;
  logic [12:0]      in_fp     = 13'h0;
  logic             out_ready = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic [12:0]      out_fp;
  logic [CNT_W-1:0] out_count;
`ifdef FP13_ACC_OVF_FLAG_EN
  logic             out_ovf;
`endif

  fp13_stream_accumulator #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fp     (in_fp),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_fp    (out_fp),
`ifdef FP13_ACC_OVF_FLAG_EN
    .out_ovf   (out_ovf),
`endif
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_pass   = 0;
  total_t      sb[$];
  logic [12:0] m_acc;
  int          m_cnt;
  bit          m_ovf;
  int          last_acc_cyc = 0;
  bit          hold_out = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic abort(input string what);
    n_checks++;
    $display("FAIL %s: wait bound expired at cycle %0d", what, cyc);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "run stopped early");
  endtask

  // Value-level reference: decode, align by integer shift, signed add, renormalise.
  function automatic void ref_add(input logic [12:0] a, input logic [12:0] b,
                                  output logic [12:0] r, output bit flag);
    int ea, eb, emax, ma, mb, va, vb, s, mag, e;
    bit neg;
    ea   = int'(a[11:8]);
    eb   = int'(b[11:8]);
    ma   = (ea == 0) ? 0 : 256 + int'(a[7:0]);
    mb   = (eb == 0) ? 0 : 256 + int'(b[7:0]);
    emax = (ea > eb) ? ea : eb;
    ma   = ma >> (emax - ea);
    mb   = mb >> (emax - eb);
    va   = a[12] ? -ma : ma;
    vb   = b[12] ? -mb : mb;
    s    = va + vb;
    neg  = (s < 0);
    mag  = neg ? -s : s;
    r    = 13'h0000;
    flag = 1'b0;
    if (mag != 0) begin
      e = emax;
      while (mag >= 512) begin mag = mag >> 1; e++; end
      while (mag < 256)  begin mag = mag << 1; e--; end
      if (e > 15) begin
        r    = {neg, 4'hF, 8'hFF};
        flag = 1'b1;
      end else if (e < 1) begin
        flag = 1'b1;
      end else begin
        r = {neg, 4'(e), 8'(mag)};
      end
    end
  endfunction

  task automatic model_clear();
    m_acc = 13'h0000;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  task automatic model_step(input logic [12:0] fp, input bit last,
                            input bit use_exp, input logic [12:0] exp_fp);
    logic [12:0] r;
    bit          f;
    total_t      t;
    ref_add(m_acc, fp, r, f);
    m_acc = r;
    if (f) m_ovf = 1'b1;
    if (m_cnt < CNT_MAX) m_cnt++;
    if (last) begin
      t.fp  = use_exp ? exp_fp : m_acc;
      t.cnt = m_cnt;
      t.ovf = m_ovf;
      sb.push_back(t);
      model_clear();
    end
  endtask

  task automatic junk();
    in_valid = 1'($urandom);
    in_fp    = 13'($urandom);
    in_last  = 1'($urandom);
  endtask

  task automatic accept(input logic [12:0] fp, input bit last,
                        input bit use_exp, input logic [12:0] exp_fp);
    int waited = 0;
    @(negedge clk);
    while (!in_ready) begin
      if (waited > 200) abort("accept wait");
      junk();
      @(negedge clk);
      waited++;
    end
    in_valid = 1'b1;
    in_fp    = fp;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid     = 1'b0;
    last_acc_cyc = cyc;
    model_step(fp, last, use_exp, exp_fp);
  endtask

  task automatic send(input logic [12:0] fp, input bit last,
                      input bit use_exp, input logic [12:0] exp_fp);
    int n;
    accept(fp, last, use_exp, exp_fp);
    if (!last) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (!in_ready) junk();
      end while (!in_ready && n < 50);
      in_valid = 1'b0;
      check("in_ready return", n, 4);
    end
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while (!(sb.size() == 0 && in_ready && !out_valid)) begin
      if (n > 500) abort("drain");
      @(negedge clk);
      n++;
    end
  endtask

  always @(posedge clk) begin
    #1;
    out_ready = hold_out ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  bit               prev_valid = 1'b0;
  bit               after_hs   = 1'b0;
  logic [12:0]      held_fp;
  logic [CNT_W-1:0] held_cnt;
  total_t           e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      after_hs   = 1'b0;
    end else begin
      if (after_hs) begin
        check("in_ready after handshake", in_ready, 1);
        check("out_valid after handshake", out_valid, 0);
        after_hs = 1'b0;
      end
      if (out_valid) begin
        check("in_ready low in DONE", in_ready, 0);
        if (!prev_valid) begin
          // accept edge -> ALIGN -> ADD -> NORM -> DONE is three further edges
          check("out_valid latency", cyc - last_acc_cyc, 3);
          held_fp  = out_fp;
          held_cnt = out_count;
        end else begin
          check("out_fp stable", out_fp, held_fp);
          check("out_count stable", out_count, held_cnt);
        end
        if (out_ready) begin
          if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected total: out_fp %0h with nothing expected", out_fp);
          end else begin
            e = sb.pop_front();
            check("out_fp", out_fp, e.fp);
            check("out_count", out_count, e.cnt);
`ifdef FP13_ACC_OVF_FLAG_EN
            check("out_ovf", out_ovf, e.ovf);
`endif
          end
          after_hs = 1'b1;
        end
      end
      prev_valid = out_valid;
    end
  end

  initial begin
    int          n;
    int          len;
    int          sel;
    logic [12:0] fp;
    model_clear();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset out_fp", out_fp, 13'h0000);
    check("reset out_count", out_count, 0);
    rst_n = 1'b1;

    send(13'h0880, 0, 0, 13'h0);
    send(13'h0940, 1, 1, 13'h0A00);
    send(13'h0880, 0, 0, 13'h0);
    send(13'h1880, 1, 1, 13'h0000);
    send(13'h0F00, 0, 0, 13'h0);
    send(13'h0780, 1, 1, 13'h0F01);
    repeat (4) send(13'h0DFC, 0, 0, 13'h0);
    send(13'h0DFC, 1, 1, 13'h0FFF);
    repeat (4) send(13'h1DFC, 0, 0, 13'h0);
    send(13'h1DFC, 1, 1, 13'h1FFF);
    send(13'h0180, 0, 0, 13'h0);
    send(13'h1100, 1, 1, 13'h0000);
    for (int i = 0; i < CNT_MAX + 4; i++) send(13'h0700, i == CNT_MAX + 3, 0, 13'h0);

    // long back-pressure with a sample offered throughout
    drain();
    hold_out = 1'b1;
    send(13'h0880, 1, 1, 13'h0880);
    n = 0;
    while (!out_valid) begin
      if (n > 50) abort("out_valid wait");
      @(negedge clk);
      n++;
    end
    repeat (10) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_fp    = 13'h0123;
      in_last  = 1'b1;
      check("in_ready held low", in_ready, 0);
    end
    in_valid = 1'b0;
    hold_out = 1'b0;
    send(13'h0700, 1, 1, 13'h0700);

    // reset while the second sample is in ADD
    drain();
    send(13'h0880, 0, 0, 13'h0);
    accept(13'h0940, 0, 0, 13'h0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset in_ready", in_ready, 1);
    check("midreset out_valid", out_valid, 0);
    check("midreset out_fp", out_fp, 13'h0000);
    check("midreset out_count", out_count, 0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    send(13'h0940, 1, 1, 13'h0940);

    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 6);
      for (int s = 0; s < len; s++) begin
        sel = $urandom_range(0, 9);
        if (sel == 0 && m_acc != 13'h0000) fp = m_acc ^ 13'h1000;
        else if (sel < 3) fp = {1'($urandom), 4'($urandom_range(1, 4)), 8'($urandom)};
        else begin
          fp = 13'($urandom);
          if ($urandom_range(0, 7) == 0) fp[11:8] = 4'd0;
        end
        send(fp, s == len - 1, 0, 13'h0);
      end
    end

    drain();
    check("scoreboard empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    abort("global watchdog");
  end

endmodule

`default_nettype wire
